udp_rx_parser: RTL and testbench

UDP_RX_PARSER -- requirements
Module: udp_rx_parser

---
 rtl/udp_pkg.sv | 19 +
 rtl/udp_rx_parser.sv | 114 +++++++++++
 tb/tb_udp_rx_parser.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/udp_pkg.sv
// Shared constants, state encoding and helpers for the UDP receive parser.
package udp_pkg;

    localparam int unsigned UDP_HDR_LEN      = 8;
    localparam logic [15:0] UDP_DEFAULT_PORT = 16'd8080;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } udp_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : 16'(v + 16'd1);
    endfunction

endpackage

// File: rtl/udp_rx_parser.sv
// UDP datagram receive parser: strips the 8-byte header, forwards payload for
// LOCAL_PORT, and counts dropped datagrams.
module udp_rx_parser
    import udp_pkg::*;
#(
    parameter logic [15:0] LOCAL_PORT = UDP_DEFAULT_PORT
) (
    input  logic        udp_rx_clk,
    input  logic        reset,
    input  logic        ip_rx_data_valid,
    input  logic [7:0]  ip_rx_data,
    input  logic        ip_rx_sof,
    output logic        app_rx_data_valid,
    output logic [7:0]  app_rx_data,
    output logic [15:0] app_rx_data_length,
    output logic [15:0] app_rx_src_port,
    output logic [15:0] drop_count
);

    localparam logic [15:0] HDR_LEN = 16'(UDP_HDR_LEN);

    udp_state_e  state_q;
    logic [15:0] byte_cnt_q;
    logic [15:0] src_q;
    logic [15:0] dst_q;
    logic [15:0] len_q;
    logic        valid_q;
    logic [7:0]  data_q;
    logic [15:0] app_len_q;
    logic [15:0] app_src_q;
    logic [15:0] drop_q;

    always_ff @(posedge udp_rx_clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            app_len_q  <= '0;
            app_src_q  <= '0;
            drop_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            if (ip_rx_data_valid && ip_rx_sof) begin
                // A new start always wins; DROP was already counted on entry.
                if (state_q == ST_HEADER || state_q == ST_PAYLOAD) begin
                    drop_q <= sat_inc16(drop_q);
                end
                state_q     <= ST_HEADER;
                byte_cnt_q  <= 16'd1;
                src_q[15:8] <= ip_rx_data;
            end else if (ip_rx_data_valid) begin
                unique case (state_q)
                    ST_IDLE: begin
                        byte_cnt_q <= '0;
                    end
                    ST_HEADER: begin
                        byte_cnt_q <= 16'(byte_cnt_q + 16'd1);
                        case (byte_cnt_q[2:0])
                            3'd1: src_q[7:0]  <= ip_rx_data;
                            3'd2: dst_q[15:8] <= ip_rx_data;
                            3'd3: dst_q[7:0]  <= ip_rx_data;
                            3'd4: len_q[15:8] <= ip_rx_data;
                            3'd5: len_q[7:0]  <= ip_rx_data;
                            3'd7: begin
                                byte_cnt_q <= '0;
                                if (len_q < HDR_LEN) begin
                                    state_q <= ST_IDLE;
                                    drop_q  <= sat_inc16(drop_q);
                                end else if (dst_q != LOCAL_PORT) begin
                                    state_q <= (len_q == HDR_LEN) ? ST_IDLE : ST_DROP;
                                    drop_q  <= sat_inc16(drop_q);
                                end else if (len_q == HDR_LEN) begin
                                    state_q <= ST_IDLE;
                                end else begin
                                    state_q   <= ST_PAYLOAD;
                                    app_len_q <= 16'(len_q - HDR_LEN);
                                    app_src_q <= src_q;
                                end
                            end
                            default: ;
                        endcase
                    end
                    ST_PAYLOAD: begin
                        valid_q    <= 1'b1;
                        data_q     <= ip_rx_data;
                        byte_cnt_q <= 16'(byte_cnt_q + 16'd1);
                        if (16'(byte_cnt_q + 16'd1) == app_len_q) begin
                            state_q    <= ST_IDLE;
                            byte_cnt_q <= '0;
                        end
                    end
                    ST_DROP: begin
                        byte_cnt_q <= 16'(byte_cnt_q + 16'd1);
                        if (16'(byte_cnt_q + 16'd1) == 16'(len_q - HDR_LEN)) begin
                            state_q    <= ST_IDLE;
                            byte_cnt_q <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign app_rx_data_valid  = valid_q;
    assign app_rx_data        = data_q;
    assign app_rx_data_length = app_len_q;
    assign app_rx_src_port    = app_src_q;
    assign drop_count         = drop_q;

endmodule

// File: tb/tb_udp_rx_parser.sv
// Directed self-checking bench for udp_rx_parser.
module tb_udp_rx_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ip_v = 1'b0;
    logic [7:0]  ip_d = 8'h00;
    logic        ip_sof = 1'b0;
    logic        app_v;
    logic [7:0]  app_d;
    logic [15:0] app_len;
    logic [15:0] app_src;
    logic [15:0] drops;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  out_d_q[$];
    logic [15:0] out_len_q[$];
    int          gap_err = 0;
    int          lat_err = 0;
    logic        prev_v = 1'b0;
    logic [7:0]  prev_d = 8'h00;

    always #5 clk = ~clk;

    udp_rx_parser #(.LOCAL_PORT(16'd8080)) dut (
        .udp_rx_clk         (clk),
        .reset              (rst_n),
        .ip_rx_data_valid   (ip_v),
        .ip_rx_data         (ip_d),
        .ip_rx_sof          (ip_sof),
        .app_rx_data_valid  (app_v),
        .app_rx_data        (app_d),
        .app_rx_data_length (app_len),
        .app_rx_src_port    (app_src),
        .drop_count         (drops)
    );

    // Input seen at the last rising edge, for latency and gap checks.
    always @(posedge clk) begin
        prev_v <= ip_v;
        prev_d <= ip_d;
    end

    always @(negedge clk) begin
        if (app_v === 1'b1) begin
            out_d_q.push_back(app_d);
            out_len_q.push_back(app_len);
            if (prev_v !== 1'b1) gap_err++;
            if (app_d !== prev_d) lat_err++;
        end
    end

    task automatic clear_mon();
        out_d_q.delete();
        out_len_q.delete();
        gap_err = 0;
        lat_err = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ip_v = 1'b0; ip_sof = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ip_v = 1'b0; ip_sof = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
    endtask

    task automatic drive_byte(input logic sof, input logic [7:0] d, input bit gaps);
        int n;
        n = gaps ? int'($urandom_range(0, 2)) : 0;
        repeat (n) begin
            @(negedge clk);
            ip_v = 1'b0; ip_sof = 1'($urandom); ip_d = 8'($urandom);
        end
        @(negedge clk);
        ip_v = 1'b1; ip_sof = sof; ip_d = d;
    endtask

    task automatic send_hdr(input logic [15:0] src, input logic [15:0] dst,
                            input logic [15:0] len, input bit gaps);
        drive_byte(1'b1, src[15:8], gaps);
        drive_byte(1'b0, src[7:0],  gaps);
        drive_byte(1'b0, dst[15:8], gaps);
        drive_byte(1'b0, dst[7:0],  gaps);
        drive_byte(1'b0, len[15:8], gaps);
        drive_byte(1'b0, len[7:0],  gaps);
        drive_byte(1'b0, 8'hCC,     gaps);
        drive_byte(1'b0, 8'hDD,     gaps);
    endtask

    task automatic send_payload(input logic [7:0] base, input int n, input bit gaps);
        for (int i = 0; i < n; i++) drive_byte(1'b0, 8'(base + 8'(i)), gaps);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (app_v !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", app_v); end
        vectors++; if (app_d !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h exp 00", app_d); end
        vectors++; if (app_len !== 16'h0000) begin miscompares++; $display("FAIL reset_len got %h exp 0000", app_len); end
        vectors++; if (app_src !== 16'h0000) begin miscompares++; $display("FAIL reset_src got %h exp 0000", app_src); end
        vectors++; if (drops !== 16'h0000) begin miscompares++; $display("FAIL reset_drop got %h exp 0000", drops); end
        rst_n = 1'b1;
        clear_mon();
    endtask

    task automatic test_basic(input bit gaps);
        do_reset();
        send_hdr(16'h1234, 16'd8080, 16'd14, gaps);
        send_payload(8'hA0, 6, gaps);
        idle(4);
        vectors++; if (out_d_q.size() != 6) begin miscompares++; $display("FAIL basic_count gaps=%0d got %0d exp 6", gaps, out_d_q.size()); end
        for (int i = 0; i < out_d_q.size() && i < 6; i++) begin
            vectors++;
            if (out_d_q[i] !== 8'(8'hA0 + 8'(i)) || out_len_q[i] !== 16'd6) begin
                miscompares++;
                $display("FAIL basic_byte%0d gaps=%0d got %h/len %0d exp %h/len 6", i, gaps, out_d_q[i], out_len_q[i], 8'(8'hA0 + 8'(i)));
            end
        end
        vectors++; if (app_len !== 16'd6) begin miscompares++; $display("FAIL basic_len got %0d exp 6", app_len); end
        vectors++; if (app_src !== 16'h1234) begin miscompares++; $display("FAIL basic_src got %h exp 1234", app_src); end
        vectors++; if (drops !== 16'd0) begin miscompares++; $display("FAIL basic_drop got %0d exp 0", drops); end
        vectors++; if (lat_err != 0) begin miscompares++; $display("FAIL basic_latency got %0d errors exp 0", lat_err); end
        vectors++; if (gap_err != 0) begin miscompares++; $display("FAIL basic_gap_pulse got %0d exp 0", gap_err); end
    endtask

    task automatic test_bad_port();
        do_reset();
        send_hdr(16'h1111, 16'd80, 16'd12, 1'b0);
        send_payload(8'h50, 4, 1'b0);
        idle(2);
        vectors++; if (out_d_q.size() != 0) begin miscompares++; $display("FAIL badport_out got %0d exp 0", out_d_q.size()); end
        vectors++; if (drops !== 16'd1) begin miscompares++; $display("FAIL badport_drop got %0d exp 1", drops); end
        send_hdr(16'h4321, 16'd8080, 16'd11, 1'b0);
        send_payload(8'hB0, 3, 1'b0);
        idle(3);
        vectors++; if (out_d_q.size() != 3) begin miscompares++; $display("FAIL badport_good_count got %0d exp 3", out_d_q.size()); end
        for (int i = 0; i < out_d_q.size() && i < 3; i++) begin
            vectors++;
            if (out_d_q[i] !== 8'(8'hB0 + 8'(i))) begin miscompares++; $display("FAIL badport_byte%0d got %h exp %h", i, out_d_q[i], 8'(8'hB0 + 8'(i))); end
        end
        vectors++; if (app_src !== 16'h4321) begin miscompares++; $display("FAIL badport_src got %h exp 4321", app_src); end
        vectors++; if (app_len !== 16'd3) begin miscompares++; $display("FAIL badport_len got %0d exp 3", app_len); end
        vectors++; if (drops !== 16'd1) begin miscompares++; $display("FAIL badport_drop2 got %0d exp 1", drops); end
    endtask

    task automatic test_short_len();
        do_reset();
        send_hdr(16'h2222, 16'd8080, 16'd8, 1'b0);
        idle(2);
        send_hdr(16'h3333, 16'd8080, 16'd5, 1'b0);
        idle(3);
        vectors++; if (out_d_q.size() != 0) begin miscompares++; $display("FAIL short_out got %0d exp 0", out_d_q.size()); end
        vectors++; if (drops !== 16'd1) begin miscompares++; $display("FAIL short_drop got %0d exp 1", drops); end
        vectors++; if (app_len !== 16'd0 || app_src !== 16'd0) begin miscompares++; $display("FAIL short_meta got len %0d src %h exp 0/0000", app_len, app_src); end
    endtask

    task automatic test_sof_abort();
        logic [7:0]  exp_d[5];
        logic [15:0] exp_l[5];
        exp_d = '{8'hD0, 8'hD1, 8'hD2, 8'hC0, 8'hC1};
        exp_l = '{16'd12, 16'd12, 16'd12, 16'd2, 16'd2};
        do_reset();
        send_hdr(16'h7777, 16'd8080, 16'd20, 1'b0);
        send_payload(8'hD0, 3, 1'b0);
        send_hdr(16'h5555, 16'd8080, 16'd10, 1'b0);
        send_payload(8'hC0, 2, 1'b0);
        idle(3);
        vectors++; if (out_d_q.size() != 5) begin miscompares++; $display("FAIL abort_count got %0d exp 5", out_d_q.size()); end
        for (int i = 0; i < out_d_q.size() && i < 5; i++) begin
            vectors++;
            if (out_d_q[i] !== exp_d[i] || out_len_q[i] !== exp_l[i]) begin
                miscompares++;
                $display("FAIL abort_byte%0d got %h/len %0d exp %h/len %0d", i, out_d_q[i], out_len_q[i], exp_d[i], exp_l[i]);
            end
        end
        vectors++; if (drops !== 16'd1) begin miscompares++; $display("FAIL abort_drop got %0d exp 1", drops); end
        vectors++; if (app_src !== 16'h5555) begin miscompares++; $display("FAIL abort_src got %h exp 5555", app_src); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_hdr(16'h9999, 16'd8080, 16'd14, 1'b0);
        send_payload(8'h60, 2, 1'b0);
        @(negedge clk);
        ip_v = 1'b1; ip_sof = 1'b0; ip_d = 8'h62; rst_n = 1'b0;
        @(negedge clk);
        vectors++; if (app_v !== 1'b0 || app_d !== 8'h00) begin miscompares++; $display("FAIL midrst_out got v=%b d=%h exp 0/00", app_v, app_d); end
        vectors++; if (app_len !== 16'd0 || app_src !== 16'd0) begin miscompares++; $display("FAIL midrst_meta got len %0d src %h exp 0/0000", app_len, app_src); end
        vectors++; if (drops !== 16'd0) begin miscompares++; $display("FAIL midrst_drop got %0d exp 0", drops); end
        rst_n = 1'b1;
        clear_mon();
        send_payload(8'h63, 4, 1'b0);
        idle(2);
        vectors++; if (out_d_q.size() != 0) begin miscompares++; $display("FAIL midrst_stray got %0d exp 0", out_d_q.size()); end
        send_hdr(16'h0BAD, 16'd8080, 16'd12, 1'b0);
        send_payload(8'hE0, 4, 1'b0);
        idle(3);
        vectors++; if (out_d_q.size() != 4) begin miscompares++; $display("FAIL midrst_good_count got %0d exp 4", out_d_q.size()); end
        for (int i = 0; i < out_d_q.size() && i < 4; i++) begin
            vectors++;
            if (out_d_q[i] !== 8'(8'hE0 + 8'(i))) begin miscompares++; $display("FAIL midrst_byte%0d got %h exp %h", i, out_d_q[i], 8'(8'hE0 + 8'(i))); end
        end
        vectors++; if (app_src !== 16'h0BAD || app_len !== 16'd4) begin miscompares++; $display("FAIL midrst_meta2 got src %h len %0d exp 0BAD/4", app_src, app_len); end
        vectors++; if (drops !== 16'd0) begin miscompares++; $display("FAIL midrst_drop2 got %0d exp 0", drops); end
    endtask

    initial begin
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_bad_port();
        test_short_len();
        test_sof_abort();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
